// File: rtl/rob_retire_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_ctrl_if
// Description : Bundle of dispatch, completion, flush and free-list signals
//               exchanged with the ROB retirement controller.
//               master : dispatch/completion side (drives requests)
//               slave  : rob_retire_ctrl (drives status and frees)
// Ports       : alloc_valid/alloc_rd_old/alloc_ready/alloc_idx  - allocation
//               cmpl_valid/cmpl_idx                            - completion
//               flush                                          - discard all
//               free_valid/free_preg0/free_preg1               - freed tags
//               count/empty                                    - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_retire_ctrl_if #(
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
);
  logic              alloc_valid;
  logic [PREG_W-1:0] alloc_rd_old;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;
  logic              cmpl_valid;
  logic [IDX_W-1:0]  cmpl_idx;
  logic              flush;
  logic [1:0]        free_valid;
  logic [PREG_W-1:0] free_preg0;
  logic [PREG_W-1:0] free_preg1;
  logic [IDX_W:0]    count;
  logic              empty;

  modport master (
    output alloc_valid, alloc_rd_old, cmpl_valid, cmpl_idx, flush,
    input  alloc_ready, alloc_idx, free_valid, free_preg0, free_preg1,
           count, empty
  );

  modport slave (
    input  alloc_valid, alloc_rd_old, cmpl_valid, cmpl_idx, flush,
    output alloc_ready, alloc_idx, free_valid, free_preg0, free_preg1,
           count, empty
  );
endinterface
`default_nettype wire

// File: rtl/rob_retire_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_ctrl
// Description : Reorder-buffer retirement controller. Allocates entries in
//               program order, records out-of-order completions and retires
//               up to two completed entries per cycle in order, returning
//               each entry's old physical destination to the free list.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - rob_retire_ctrl_if.slave (alloc/cmpl/flush in,
//                       alloc_ready/alloc_idx/count/empty/free_* out)
// Revision    : 1.0 - initial release
// ============================================================================
module rob_retire_ctrl #(
  parameter int ROB_SIZE = 16,
  parameter int IDX_W    = 4,
  parameter int PREG_W   = 6
) (
  input  wire               clk,
  input  wire               rst_n,
  rob_retire_ctrl_if.slave  bus
);

  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] comp_q, comp_d;
  logic [PREG_W-1:0] rd_old_q [ROB_SIZE];
  logic [PREG_W-1:0] rd_old_d [ROB_SIZE];
  logic [1:0]        free_valid_q, free_valid_d;
  logic [PREG_W-1:0] free_preg0_q, free_preg0_d;
  logic [PREG_W-1:0] free_preg1_q, free_preg1_d;

  logic [IDX_W-1:0]  head_p1;
  logic              alloc_ready;
  logic              alloc_fire;
  logic              r0;
  logic              r1;

  always_comb begin
    head_p1     = head_q + IDX_W'(1);
    // Full blocks allocation even if a retire frees a slot this cycle;
    // the freed slot becomes visible through count_q next cycle.
    alloc_ready = (count_q < CNT_W'(ROB_SIZE));
    alloc_fire  = bus.alloc_valid && alloc_ready;

    // Retirement looks only at registered bits, so a completion arriving
    // this cycle cannot retire before the next edge.
    r0 = valid_q[head_q] && comp_q[head_q];
    r1 = r0 && valid_q[head_p1] && comp_q[head_p1];

    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    valid_d      = valid_q;
    comp_d       = comp_q;
    rd_old_d     = rd_old_q;
    free_valid_d = {r1, r0};
    free_preg0_d = rd_old_q[head_q];
    free_preg1_d = rd_old_q[head_p1];

    if (bus.flush) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      valid_d      = '0;
      comp_d       = '0;
      free_valid_d = 2'b00;
    end else begin
      if (bus.cmpl_valid && valid_q[bus.cmpl_idx]) begin
        comp_d[bus.cmpl_idx] = 1'b1;
      end
      // Retiring entries are valid and the allocated tail entry is not, so
      // the clears below never collide with the allocation write.
      if (r0) begin
        valid_d[head_q] = 1'b0;
        comp_d[head_q]  = 1'b0;
      end
      if (r1) begin
        valid_d[head_p1] = 1'b0;
        comp_d[head_p1]  = 1'b0;
      end
      if (alloc_fire) begin
        valid_d[tail_q]  = 1'b1;
        comp_d[tail_q]   = 1'b0;
        rd_old_d[tail_q] = bus.alloc_rd_old;
        tail_d           = tail_q + IDX_W'(1);
      end
      head_d  = head_q + IDX_W'(r0) + IDX_W'(r1);
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(r0) - CNT_W'(r1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      comp_q       <= '0;
      free_valid_q <= 2'b00;
      free_preg0_q <= '0;
      free_preg1_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_old_q[i] <= '0;
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      comp_q       <= comp_d;
      free_valid_q <= free_valid_d;
      free_preg0_q <= free_preg0_d;
      free_preg1_q <= free_preg1_d;
      rd_old_q     <= rd_old_d;
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_idx   = tail_q;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);
  assign bus.free_valid  = free_valid_q;
  assign bus.free_preg0  = free_preg0_q;
  assign bus.free_preg1  = free_preg1_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_retire_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_retire_ctrl
// Description : Self-checking bench for rob_retire_ctrl. A queue-based model
//               of the in-flight instructions predicts every output and is
//               compared on each falling edge; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_retire_ctrl;

  localparam int ROB_SIZE = 16;
  localparam int IDX_W    = 4;
  localparam int PREG_W   = 6;

  logic clk;
  logic rst_n;

  rob_retire_ctrl_if #(.IDX_W(IDX_W), .PREG_W(PREG_W)) bus ();

  rob_retire_ctrl #(
    .ROB_SIZE (ROB_SIZE),
    .IDX_W    (IDX_W),
    .PREG_W   (PREG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: in-flight instructions in order ------
  typedef struct {
    int idx;
    int rd;
    bit done;
  } ent_t;

  ent_t m_q[$];
  int   m_head;
  int   m_n;
  int   m_sz;
  ent_t m_e;
  int   exp_fv;
  int   exp_p0;
  int   exp_p1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      m_q.delete();
      m_head = 0;
      exp_fv = 0;
    end else begin
      m_sz = m_q.size();
      m_n  = 0;
      if (m_sz > 0 && m_q[0].done) begin
        m_n    = 1;
        exp_p0 = m_q[0].rd;
        if (m_sz > 1 && m_q[1].done) begin
          m_n    = 2;
          exp_p1 = m_q[1].rd;
        end
      end
      if (bus.cmpl_valid) begin
        foreach (m_q[i]) begin
          if (m_q[i].idx == int'(bus.cmpl_idx)) m_q[i].done = 1'b1;
        end
      end
      if (bus.alloc_valid && m_sz < ROB_SIZE) begin
        m_e.idx  = (m_head + m_sz) % ROB_SIZE;
        m_e.rd   = int'(bus.alloc_rd_old);
        m_e.done = 1'b0;
        m_q.push_back(m_e);
      end
      repeat (m_n) void'(m_q.pop_front());
      m_head = (m_head + m_n) % ROB_SIZE;
      exp_fv = (m_n == 2) ? 3 : (m_n == 1) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    check("m_alloc_ready", int'(bus.alloc_ready), (m_q.size() < ROB_SIZE) ? 1 : 0);
    check("m_alloc_idx", int'(bus.alloc_idx), (m_head + m_q.size()) % ROB_SIZE);
    check("m_count", int'(bus.count), m_q.size());
    check("m_empty", int'(bus.empty), (m_q.size() == 0) ? 1 : 0);
    check("m_free_valid", int'(bus.free_valid), exp_fv);
    if (exp_fv >= 1) check("m_free_preg0", int'(bus.free_preg0), exp_p0);
    if (exp_fv == 3) check("m_free_preg1", int'(bus.free_preg1), exp_p1);
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic cycle(input bit av, input int rd, input bit cv, input int ci,
                       input bit fl);
    bus.alloc_valid  = av;
    bus.alloc_rd_old = PREG_W'(rd);
    bus.cmpl_valid   = cv;
    bus.cmpl_idx     = IDX_W'(ci);
    bus.flush        = fl;
    @(posedge clk);
    #1;
    bus.alloc_valid = 1'b0;
    bus.cmpl_valid  = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.alloc_valid  = 1'b0;
    bus.alloc_rd_old = '0;
    bus.cmpl_valid   = 1'b0;
    bus.cmpl_idx     = '0;
    bus.flush        = 1'b0;

    // Reset values
    #2;
    check("rst_alloc_ready", int'(bus.alloc_ready), 1);
    check("rst_alloc_idx", int'(bus.alloc_idx), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_free_valid", int'(bus.free_valid), 0);
    check("rst_free_preg0", int'(bus.free_preg0), 0);
    check("rst_free_preg1", int'(bus.free_preg1), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Out-of-order completion
    cycle(1, 10, 0, 0, 0);
    cycle(1, 11, 0, 0, 0);
    cycle(1, 12, 0, 0, 0);
    cycle(0, 0, 1, 2, 0);
    cycle(0, 0, 1, 0, 0);
    check("ooo_no_free_yet", int'(bus.free_valid), 0);
    cycle(0, 0, 1, 1, 0);
    check("ooo_single_valid", int'(bus.free_valid), 1);
    check("ooo_single_preg0", int'(bus.free_preg0), 10);
    idle(1);
    check("ooo_dual_valid", int'(bus.free_valid), 3);
    check("ooo_dual_preg0", int'(bus.free_preg0), 11);
    check("ooo_dual_preg1", int'(bus.free_preg1), 12);
    check("ooo_count_end", int'(bus.count), 0);
    idle(1);

    // Asynchronous reset mid-operation with a retire pending
    cycle(1, 7, 0, 0, 0);
    cycle(1, 8, 1, 3, 0);
    cycle(0, 0, 1, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_count", int'(bus.count), 0);
    check("mrst_empty", int'(bus.empty), 1);
    check("mrst_free_valid", int'(bus.free_valid), 0);
    check("mrst_alloc_idx", int'(bus.alloc_idx), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // Full
    for (int i = 0; i < ROB_SIZE; i++) cycle(1, 20 + i, 0, 0, 0);
    check("full_count", int'(bus.count), 16);
    check("full_alloc_ready", int'(bus.alloc_ready), 0);
    cycle(1, 63, 0, 0, 0);
    check("full_17th_count", int'(bus.count), 16);
    check("full_17th_idx", int'(bus.alloc_idx), 0);
    cycle(0, 0, 1, 0, 0);
    check("full_ready_still0", int'(bus.alloc_ready), 0);
    idle(1);
    check("full_free_valid", int'(bus.free_valid), 1);
    check("full_free_preg0", int'(bus.free_preg0), 20);
    check("full_ready_back", int'(bus.alloc_ready), 1);
    check("full_next_idx", int'(bus.alloc_idx), 0);
    cycle(1, 40, 0, 0, 0);
    check("full_refill_count", int'(bus.count), 16);

    // Flush with 5 in flight, 2 complete, together with alloc and cmpl
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1 + i, 0, 0, 0);
    cycle(0, 0, 1, 3, 0);
    cycle(0, 0, 1, 4, 0);
    cycle(1, 9, 1, 0, 1);
    check("flush_count", int'(bus.count), 0);
    check("flush_empty", int'(bus.empty), 1);
    check("flush_free_valid", int'(bus.free_valid), 0);
    check("flush_alloc_idx", int'(bus.alloc_idx), 0);
    idle(2);

    // Wrap: walk head/tail to 15, then dual retire across the wrap
    for (int i = 0; i < 15; i++) cycle(1, i, (i > 0), i - 1, 0);
    cycle(0, 0, 1, 14, 0);
    idle(2);
    check("wrap_start_idx", int'(bus.alloc_idx), 15);
    cycle(1, 50, 0, 0, 0);
    cycle(1, 51, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 15, 0);
    idle(1);
    check("wrap_free_valid", int'(bus.free_valid), 3);
    check("wrap_free_preg0", int'(bus.free_preg0), 50);
    check("wrap_free_preg1", int'(bus.free_preg1), 51);
    check("wrap_head_idx", int'(bus.alloc_idx), 1);
    check("wrap_count", int'(bus.count), 0);
    idle(1);

    // Simultaneous alloc idx 3, complete head idx 1, retire idx 0
    cycle(0, 0, 0, 0, 1);
    cycle(1, 30, 0, 0, 0);
    cycle(1, 31, 0, 0, 0);
    cycle(1, 32, 1, 0, 0);
    cycle(1, 33, 1, 1, 0);
    check("sim_count", int'(bus.count), 3);
    check("sim_free_valid", int'(bus.free_valid), 1);
    check("sim_free_preg0", int'(bus.free_preg0), 30);
    idle(1);
    check("sim_next_valid", int'(bus.free_valid), 1);
    check("sim_next_preg0", int'(bus.free_preg0), 31);
    check("sim_next_count", int'(bus.count), 2);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
